mips_io_display: RTL and testbench

Memory-mapped output peripheral for the multicycle MIPS system. It sits downstream of the CPU on the shared memory bus, next to `Memory`. It snoops store cycles, and a store to its I/O address latches the 32-bit word into a display register. It then shows 16 bits of that register on a time-multiplexed 4-digit seven-segment display, so programs can expose results on the board without a debugger.

---
 rtl/mips_io_display_if.sv | 10 +
 rtl/mips_io_display.sv | 129 ++++++++++++
 tb/tb_mips_io_display.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_io_display_if.sv
// rtl/mips_io_display_if.sv - CPU memory-bus signals snooped by the I/O display peripheral
interface mips_io_display_if;
  logic        CS;
  logic        WE;
  logic [6:0]  ADDR;
  logic [31:0] Mem_Bus;

  modport master (output CS, WE, ADDR, Mem_Bus);
  modport slave  (input  CS, WE, ADDR, Mem_Bus);
endinterface

// File: rtl/mips_io_display.sv
// rtl/mips_io_display.sv - store-snooping display register driving a muxed 4-digit seven-segment display
// Optional leading-zero blanking: define DISP_LZB_EN.
module mips_io_display #(
  parameter logic [6:0] IO_ADDR     = 7'h7F,
  parameter int         REFRESH_DIV = 100000,
  parameter int         CNT_W       = 17
) (
  input  logic               CLK,
  input  logic               RST,
  mips_io_display_if.slave   bus,
  input  logic               HALF_SEL,
  output logic [31:0]        D_Out,
  output logic               upd,
  output logic [3:0]         AN,
  output logic [6:0]         SEG,
  output logic               DP
);

  localparam logic [CNT_W-1:0] RC_MAX = CNT_W'(REFRESH_DIV - 1);

  logic             cap;
  logic             half_meta, half_q;
  logic [CNT_W-1:0] rcnt;
  logic [1:0]       dig, dig_nxt;
  logic [15:0]      shadow, shadow_nxt;
  logic             half_s, half_s_nxt;
  logic             rwrap, frame;
  logic [3:0]       nib_nxt;
  logic             blank_nxt;
  logic [3:0]       an_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign cap = bus.CS && bus.WE && (bus.ADDR == IO_ADDR);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      D_Out <= 32'd0;
      upd   <= 1'b0;
    end else begin
      upd <= cap;
      if (cap) D_Out <= bus.Mem_Bus;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      half_meta <= 1'b0;
      half_q    <= 1'b0;
    end else begin
      half_meta <= HALF_SEL;
      half_q    <= half_meta;
    end
  end

  // Outputs are registered from the next-state view of dig/shadow so the
  // anodes and segments switch on the same edge as the digit index.
  always_comb begin
    rwrap      = (rcnt == RC_MAX);
    dig_nxt    = rwrap ? dig + 2'd1 : dig;
    frame      = rwrap && (dig == 2'd3);
    shadow_nxt = shadow;
    half_s_nxt = half_s;
    if (frame) begin
      shadow_nxt = half_q ? D_Out[31:16] : D_Out[15:0];
      half_s_nxt = half_q;
    end
    nib_nxt = shadow_nxt[{dig_nxt, 2'b00} +: 4];
    an_nxt  = ~(4'b0001 << dig_nxt);
    seg_nxt = hex7(nib_nxt);
    dp_nxt  = ~((dig_nxt == 2'd3) && half_s_nxt);
`ifdef DISP_LZB_EN
    case (dig_nxt)
      2'd3:    blank_nxt = (shadow_nxt[15:12] == 4'd0);
      2'd2:    blank_nxt = (shadow_nxt[15:8]  == 8'd0);
      2'd1:    blank_nxt = (shadow_nxt[15:4]  == 12'd0);
      default: blank_nxt = 1'b0;
    endcase
`else
    blank_nxt = 1'b0;
`endif
    if (blank_nxt) begin
      an_nxt  = 4'b1111;
      seg_nxt = 7'b1111111;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rcnt   <= '0;
      dig    <= 2'd0;
      shadow <= 16'd0;
      half_s <= 1'b0;
      AN     <= 4'b1110;
      SEG    <= 7'b1000000;
      DP     <= 1'b1;
    end else begin
      rcnt   <= rwrap ? '0 : rcnt + 1'b1;
      dig    <= dig_nxt;
      shadow <= shadow_nxt;
      half_s <= half_s_nxt;
      AN     <= an_nxt;
      SEG    <= seg_nxt;
      DP     <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_mips_io_display.sv
// tb/tb_mips_io_display.sv - vector table, directed frame sequences and random stores against a cycle-count model
module tb_mips_io_display;
  localparam int RD    = 4;
  localparam int FRAME = 4 * RD;

  logic        CLK = 1'b0;
  logic        RST;
  logic        HALF_SEL;
  logic [31:0] D_Out;
  logic        upd;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;

  always #5 CLK = ~CLK;

  mips_io_display_if bus();

  mips_io_display #(.IO_ADDR(7'h7F), .REFRESH_DIV(RD), .CNT_W(2)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .HALF_SEL(HALF_SEL),
    .D_Out(D_Out), .upd(upd), .AN(AN), .SEG(SEG), .DP(DP)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model: k counts clock edges since reset; digit = (k/RD)%4, frame start when k is a multiple of 4*RD.
  int          m_k;
  logic [31:0] m_dout;
  logic        m_upd, m_h1, m_h2, m_halfs, m_cap;
  logic [15:0] m_shadow;
  bit          chk_en = 0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_k = 0; m_dout = 0; m_upd = 0; m_h1 = 0; m_h2 = 0; m_halfs = 0; m_shadow = 0;
    end else begin
      m_cap = bus.CS && bus.WE && (bus.ADDR == 7'h7F);
      m_k++;
      if (m_k % FRAME == 0) begin
        m_shadow = m_h2 ? m_dout[31:16] : m_dout[15:0];
        m_halfs  = m_h2;
      end
      m_h2  = m_h1;
      m_h1  = HALF_SEL;
      m_upd = m_cap;
      if (m_cap) m_dout = bus.Mem_Bus;
    end
  end

  function automatic logic [11:0] exp_disp();
    int d;
    logic [3:0] an;
    logic [6:0] seg;
    logic dp;
    d   = (m_k / RD) % 4;
    an  = 4'hF ^ 4'(1 << d);
    seg = seg_tab[(m_shadow >> (4 * d)) & 16'hF];
    dp  = !(d == 3 && m_halfs);
`ifdef DISP_LZB_EN
    if (d != 0 && (m_shadow >> (4 * d)) == 0) begin
      an  = 4'hF;
      seg = 7'h7F;
    end
`endif
    return {an, seg, dp};
  endfunction

  always @(negedge CLK) begin
    if (chk_en && !RST) begin
      check("model_dout", D_Out, m_dout);
      check("model_upd", upd, m_upd);
      check("model_disp", {AN, SEG, DP}, exp_disp());
    end
  end

  task automatic drive(input logic cs, input logic we, input logic [6:0] a, input logic [31:0] d);
    bus.CS = cs; bus.WE = we; bus.ADDR = a; bus.Mem_Bus = d;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic align(input int r);
    for (int i = 0; i < 3 * FRAME && (m_k % FRAME) != r; i++) @(negedge CLK);
    if ((m_k % FRAME) != r) begin
      n_cmp++; n_bad++;
      $display("FAIL align: phase %0d expected %0d", m_k % FRAME, r);
    end
  endtask

  typedef struct {
    logic        cs, we;
    logic [6:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_dout;
    logic        exp_upd;
  } vec_t;

  vec_t vecs [8];
  logic [6:0] lo_seg [4] = '{7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000};
  logic [6:0] hi_seg [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

  initial begin
    vecs[0] = '{1, 1, 7'h7F, 32'h1234ABCD, 32'h1234ABCD, 1};
    vecs[1] = '{0, 0, 7'h00, 32'h00000000, 32'h1234ABCD, 0};
    vecs[2] = '{1, 1, 7'h10, 32'hDEADBEEF, 32'h1234ABCD, 0};
    vecs[3] = '{1, 0, 7'h7F, 32'hDEADBEEF, 32'h1234ABCD, 0};
    vecs[4] = '{0, 1, 7'h7F, 32'hDEADBEEF, 32'h1234ABCD, 0};
    vecs[5] = '{1, 1, 7'h7F, 32'hCAFEF00D, 32'hCAFEF00D, 1};
    vecs[6] = '{1, 1, 7'h7F, 32'h1234ABCD, 32'h1234ABCD, 1};
    vecs[7] = '{0, 0, 7'h00, 32'h00000000, 32'h1234ABCD, 0};

    RST = 1'b1; HALF_SEL = 1'b0;
    drive(0, 0, 7'h0, 32'h0);
    step(3);
    check("rst_dout", D_Out, 32'h0);
    check("rst_upd", upd, 1'b0);
    check("rst_an", AN, 4'b1110);
    check("rst_seg", SEG, 7'b1000000);
    check("rst_dp", DP, 1'b1);
    RST = 1'b0;
    chk_en = 1;

    // Capture landing on the frame-start edge: this frame keeps the old value.
    align(FRAME - 1);
    drive(1, 1, 7'h7F, 32'h00000007);
    step(1);
    drive(0, 0, 7'h0, 32'h0);
    check("fs_dout", D_Out, 32'h7);
    check("fs_upd", upd, 1'b1);
    check("fs_seg_old", SEG, 7'b1000000);
    step(FRAME);
    check("fs_seg_new", SEG, 7'b1111000);

    // Blanking pattern 00000005.
    drive(1, 1, 7'h7F, 32'h00000005);
    step(1);
    drive(0, 0, 7'h0, 32'h0);
    align(0);
    for (int d = 0; d < 4; d++) begin
`ifdef DISP_LZB_EN
      check("lzb_an", AN, d == 0 ? 4'b1110 : 4'b1111);
      check("lzb_seg", SEG, d == 0 ? 7'b0010010 : 7'b1111111);
`else
      check("nolzb_an", AN, 4'hF ^ 4'(1 << d));
      check("nolzb_seg", SEG, d == 0 ? 7'b0010010 : 7'b1000000);
`endif
      step(RD);
    end

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].cs, vecs[i].we, vecs[i].addr, vecs[i].data);
      step(1);
      check("vec_dout", D_Out, vecs[i].exp_dout);
      check("vec_upd", upd, vecs[i].exp_upd);
    end
    drive(0, 0, 7'h0, 32'h0);

    align(0);
    for (int d = 0; d < 4; d++) begin
      check("lo_an", AN, 4'hF ^ 4'(1 << d));
      check("lo_seg", SEG, lo_seg[d]);
      check("lo_dp", DP, 1'b1);
      step(RD);
    end

    // Half switch at digit 1 takes effect only at the next frame.
    align(RD);
    HALF_SEL = 1'b1;
    align(3 * RD);
    check("hs_same_seg", SEG, 7'b0001000);
    check("hs_same_dp", DP, 1'b1);
    align(0);
    for (int d = 0; d < 4; d++) begin
      check("hi_seg", SEG, hi_seg[d]);
      check("hi_dp", DP, d == 3 ? 1'b0 : 1'b1);
      step(RD);
    end

    // Asynchronous reset mid-frame.
    drive(1, 1, 7'h7F, 32'hFFFFFFFF);
    step(1);
    drive(0, 0, 7'h0, 32'h0);
    align(2 * RD);
    #2 RST = 1'b1;
    #1;
    check("amid_dout", D_Out, 32'h0);
    check("amid_upd", upd, 1'b0);
    check("amid_an", AN, 4'b1110);
    check("amid_seg", SEG, 7'b1000000);
    check("amid_dp", DP, 1'b1);
    step(1);
    RST = 1'b0;
    HALF_SEL = 1'b0;

    for (int i = 0; i < 800; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 1) ? 7'h7F : 7'($urandom), $urandom);
      if ($urandom_range(0, 63) == 0) HALF_SEL = ~HALF_SEL;
      step(1);
    end
    drive(0, 0, 7'h0, 32'h0);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
